// File: rtl/counter_min_hour_pkg.sv
// Shared constants and types for the minutes/hours stage of the wall clock.
package counter_min_hour_pkg;

  localparam int MIN_TENS_MAX = 5;
  localparam int UNITS_MAX    = 9;
  localparam int HOUR24_MAX   = 23;
  localparam int HOUR12_MIN   = 1;
  localparam int HOUR12_MAX   = 12;

  // One bit per edge-detected input level.
  typedef struct packed {
    logic carry;
    logic smin;
    logic shour;
  } edge_t;

endpackage

// File: rtl/counter_min_hour_if.sv
// Control inputs and BCD display outputs of the minutes/hours stage.
interface counter_min_hour_if;
  logic       carry_sec;
  logic       load_mh;
  logic       set_min;
  logic       set_hour;
  logic [2:0] min_tens;
  logic [3:0] min_units;
  logic [1:0] hour_tens;
  logic [3:0] hour_units;
  logic       pm;
  logic       carry_day;

  modport master (
    output carry_sec, load_mh, set_min, set_hour,
    input  min_tens, min_units, hour_tens, hour_units, pm, carry_day
  );

  modport slave (
    input  carry_sec, load_mh, set_min, set_hour,
    output min_tens, min_units, hour_tens, hour_units, pm, carry_day
  );
endinterface

// File: rtl/counter_min_hour_bcd.sv
// Two-digit BCD counter: +1 on inc_i, wraps from MAX_VAL to RLD_VAL.
// wrap_o flags that the current value is the wrap value.
module bcd_mod_counter
  import counter_min_hour_pkg::*;
#(
  parameter int TENS_W  = 3,
  parameter int MAX_VAL = 59,
  parameter int RLD_VAL = 0,
  parameter int RST_VAL = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              inc_i,
  output logic [TENS_W-1:0] tens_o,
  output logic [3:0]        units_o,
  output logic              wrap_o
);

  localparam logic [TENS_W-1:0] MAX_T = TENS_W'(MAX_VAL / 10);
  localparam logic [3:0]        MAX_U = 4'(MAX_VAL % 10);
  localparam logic [TENS_W-1:0] RLD_T = TENS_W'(RLD_VAL / 10);
  localparam logic [3:0]        RLD_U = 4'(RLD_VAL % 10);
  localparam logic [TENS_W-1:0] RST_T = TENS_W'(RST_VAL / 10);
  localparam logic [3:0]        RST_U = 4'(RST_VAL % 10);

  logic [TENS_W-1:0] tens_q, tens_d;
  logic [3:0]        units_q, units_d;

  assign wrap_o  = (tens_q == MAX_T) && (units_q == MAX_U);
  assign tens_o  = tens_q;
  assign units_o = units_q;

  // Next value: reload at the wrap value, otherwise BCD increment.
  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (inc_i) begin
      if (wrap_o) begin
        tens_d  = RLD_T;
        units_d = RLD_U;
      end else if (units_q == 4'(UNITS_MAX)) begin
        units_d = 4'd0;
        tens_d  = tens_q + TENS_W'(1);
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  // Digit registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tens_q  <= RST_T;
      units_q <= RST_U;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

endmodule

// File: rtl/counter_min_hour.sv
// Minutes/hours stage: edge detection on the seconds carry and set pulses,
// set-mode priority, 12/24-hour wrapping, pm flag and midnight pulse.
module counter_min_hour
  import counter_min_hour_pkg::*;
#(
  parameter bit HOUR_12 = 1'b0
) (
  input  logic              clock,
  input  logic              reset_n,
  counter_min_hour_if.slave bus
);

  localparam int H_MAX = HOUR_12 ? HOUR12_MAX : HOUR24_MAX;
  localparam int H_RLD = HOUR_12 ? HOUR12_MIN : 0;
  localparam int H_RST = HOUR_12 ? HOUR12_MAX : 0;
  localparam int M_MAX = MIN_TENS_MAX * 10 + UNITS_MAX;

  edge_t lvl, prev_q, edg;
  logic  min_inc, hour_inc, min_wrap, hour_wrap, hour_is_11;
  logic  pm_q, pm_d, cday_q, cday_d;
  logic [2:0] mt;
  logic [3:0] mu;
  logic [1:0] ht;
  logic [3:0] hu;

  assign lvl = '{carry: bus.carry_sec, smin: bus.set_min, shour: bus.set_hour};
  assign edg = lvl & ~prev_q;

  // Previous-level registers; reset high so a level held through reset is not an edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) prev_q <= '1;
    else          prev_q <= lvl;
  end

  assign hour_is_11 = (ht == 2'd1) && (hu == 4'd1);

  // Increment requests: set mode takes the set pulses and drops the carry.
  always_comb begin
    min_inc  = 1'b0;
    hour_inc = 1'b0;
    cday_d   = 1'b0;
    if (bus.load_mh) begin
      min_inc  = edg.smin;
      hour_inc = edg.shour;
    end else if (edg.carry) begin
      min_inc  = 1'b1;
      hour_inc = min_wrap;
      cday_d   = min_wrap && (HOUR_12 ? (hour_is_11 && pm_q) : hour_wrap);
    end
  end

  // pm flips whenever the hour steps from 11 to 12.
  always_comb begin
    pm_d = HOUR_12 ? (pm_q ^ (hour_inc && hour_is_11)) : 1'b0;
  end

  // pm and midnight pulse registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pm_q   <= 1'b0;
      cday_q <= 1'b0;
    end else begin
      pm_q   <= pm_d;
      cday_q <= cday_d;
    end
  end

  bcd_mod_counter #(.TENS_W(3), .MAX_VAL(M_MAX), .RLD_VAL(0), .RST_VAL(0)) u_min (
    .clock   (clock),
    .reset_n (reset_n),
    .inc_i   (min_inc),
    .tens_o  (mt),
    .units_o (mu),
    .wrap_o  (min_wrap)
  );

  bcd_mod_counter #(.TENS_W(2), .MAX_VAL(H_MAX), .RLD_VAL(H_RLD), .RST_VAL(H_RST)) u_hour (
    .clock   (clock),
    .reset_n (reset_n),
    .inc_i   (hour_inc),
    .tens_o  (ht),
    .units_o (hu),
    .wrap_o  (hour_wrap)
  );

  assign bus.min_tens   = mt;
  assign bus.min_units  = mu;
  assign bus.hour_tens  = ht;
  assign bus.hour_units = hu;
  assign bus.pm         = pm_q;
  assign bus.carry_day  = cday_q;

endmodule

// File: tb/tb_counter_min_hour.sv
// Bench for counter_min_hour: 24h and 12h instances driven by the same inputs,
// checked against a minutes-of-day reference model plus directed sequences.
module tb_counter_min_hour;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic c = 1'b0, l = 1'b0, sm = 1'b0, sh = 1'b0;

  always #5 clock = ~clock;

  counter_min_hour_if bus24 ();
  counter_min_hour_if bus12 ();

  assign bus24.carry_sec = c;  assign bus12.carry_sec = c;
  assign bus24.load_mh   = l;  assign bus12.load_mh   = l;
  assign bus24.set_min   = sm; assign bus12.set_min   = sm;
  assign bus24.set_hour  = sh; assign bus12.set_hour  = sh;

  counter_min_hour #(.HOUR_12(1'b0)) dut24 (.clock(clock), .reset_n(reset_n), .bus(bus24));
  counter_min_hour #(.HOUR_12(1'b1)) dut12 (.clock(clock), .reset_n(reset_n), .bus(bus12));

  int errs = 0, checks = 0, cday_cnt = 0;

  // Reference model: time of day as hour 0..23 and minute 0..59.
  int mh, mm;
  bit mcd, pc, pm_, ph;

  function automatic logic [14:0] exp_pack(int h, int m, bit cd, bit is12);
    int hd; bit p;
    if (is12) begin hd = (h % 12 == 0) ? 12 : h % 12; p = (h >= 12); end
    else begin hd = h; p = 1'b0; end
    return {3'(m / 10), 4'(m % 10), 2'(hd / 10), 4'(hd % 10), p, cd};
  endfunction

  function automatic logic [14:0] act24();
    return {bus24.min_tens, bus24.min_units, bus24.hour_tens, bus24.hour_units, bus24.pm, bus24.carry_day};
  endfunction

  function automatic logic [14:0] act12();
    return {bus12.min_tens, bus12.min_units, bus12.hour_tens, bus12.hour_units, bus12.pm, bus12.carry_day};
  endfunction

  task automatic chk(string name, logic [14:0] act, logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (mt,mu,ht,hu,pm,cday)", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mh = 0; mm = 0; mcd = 1'b0; pc = 1'b1; pm_ = 1'b1; ph = 1'b1;
  endtask

  task automatic model_step(bit ci, bit li, bit smi, bit shi);
    bit ce, me, he;
    int t;
    ce = ci && !pc; me = smi && !pm_; he = shi && !ph;
    mcd = 1'b0;
    if (li) begin
      if (me) mm = (mm + 1) % 60;
      if (he) mh = (mh + 1) % 24;
    end else if (ce) begin
      t = mh * 60 + mm + 1;
      if (t == 1440) begin t = 0; mcd = 1'b1; end
      mh = t / 60; mm = t % 60;
    end
    pc = ci; pm_ = smi; ph = shi;
  endtask

  // One clock: drive inputs, update model at the edge, compare just after it.
  task automatic tick(bit ci, bit li, bit smi, bit shi);
    c = ci; l = li; sm = smi; sh = shi;
    @(posedge clock);
    model_step(ci, li, smi, shi);
    #1;
    if (bus24.carry_day || bus12.carry_day) cday_cnt++;
    chk("model24", act24(), exp_pack(mh, mm, mcd, 1'b0));
    chk("model12", act12(), exp_pack(mh, mm, mcd, 1'b1));
  endtask

  task automatic set_time(int h, int m);
    int nh = (h - mh + 24) % 24;
    int nm = (m - mm + 60) % 60;
    tick(0, 1, 0, 0);
    repeat (nh) begin tick(0, 1, 0, 1); tick(0, 1, 0, 0); end
    repeat (nm) begin tick(0, 1, 1, 0); tick(0, 1, 0, 0); end
    tick(0, 0, 0, 0);
  endtask

  typedef struct { bit c, l, sm, sh; int h, m; bit cd; } vec_t;
  vec_t tbl[12];

  initial begin
    // Set-mode corner cases starting from 10:59 in run mode.
    tbl[0]  = '{0, 1, 0, 0, 10, 59, 0};
    tbl[1]  = '{1, 1, 0, 0, 10, 59, 0};  // carry dropped in set mode
    tbl[2]  = '{0, 1, 0, 0, 10, 59, 0};
    tbl[3]  = '{0, 1, 1, 0, 10,  0, 0};  // minute wraps, no hour carry
    tbl[4]  = '{0, 1, 0, 0, 10,  0, 0};
    tbl[5]  = '{0, 1, 1, 1, 11,  1, 0};  // both fields at once
    tbl[6]  = '{0, 1, 0, 0, 11,  1, 0};
    tbl[7]  = '{1, 1, 0, 0, 11,  1, 0};
    tbl[8]  = '{1, 0, 0, 0, 11,  1, 0};  // leave set mode with carry high
    tbl[9]  = '{0, 0, 0, 0, 11,  1, 0};
    tbl[10] = '{1, 0, 1, 1, 11,  2, 0};  // set pulses ignored in run mode
    tbl[11] = '{1, 0, 0, 0, 11,  2, 0};

    // Reset with carry held high: no increment on release.
    c = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset24", act24(), exp_pack(0, 0, 0, 0));
    chk("reset12", act12(), exp_pack(0, 0, 0, 1));
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) tick(1, 0, 0, 0);
    chk("hold24", act24(), exp_pack(0, 0, 0, 0));
    chk("hold12", act12(), {3'd0, 4'd0, 2'd1, 4'd2, 1'b0, 1'b0});
    tick(0, 0, 0, 0);

    // 60 one-cycle pulses: 00:00 -> 01:00 without a day carry.
    cday_cnt = 0;
    repeat (60) begin tick(1, 0, 0, 0); tick(0, 0, 0, 0); end
    chk("60p24", act24(), exp_pack(1, 0, 0, 0));
    chk("60p12", act12(), exp_pack(1, 0, 0, 1));
    checks++;
    if (cday_cnt != 0) begin errs++; $display("FAIL 60p_cday: got %0d pulses expected 0", cday_cnt); end

    // Midnight rollover from 23:58.
    set_time(23, 58);
    chk("pre2358", act24(), {3'd5, 4'd8, 2'd2, 4'd3, 1'b0, 1'b0});
    tick(1, 0, 0, 0);
    chk("2359", act24(), exp_pack(23, 59, 0, 0));
    tick(0, 0, 0, 0);
    cday_cnt = 0;
    tick(1, 0, 0, 0);
    chk("midn24", act24(), exp_pack(0, 0, 1, 0));
    chk("midn12", act12(), {3'd0, 4'd0, 2'd1, 4'd2, 1'b0, 1'b1});
    tick(0, 0, 0, 0);
    chk("midn24_off", act24(), exp_pack(0, 0, 0, 0));
    checks++;
    if (cday_cnt != 1) begin errs++; $display("FAIL cday_width: got %0d cycles expected 1", cday_cnt); end

    // 12-hour wraps: 11:59 AM -> 12:00 PM, 12:59 PM -> 01:00 PM.
    set_time(11, 59);
    chk("pre1159am", act12(), {3'd5, 4'd9, 2'd1, 4'd1, 1'b0, 1'b0});
    tick(1, 0, 0, 0); tick(0, 0, 0, 0);
    chk("noon12", act12(), {3'd0, 4'd0, 2'd1, 4'd2, 1'b1, 1'b0});
    set_time(12, 59);
    tick(1, 0, 0, 0); tick(0, 0, 0, 0);
    chk("1pm12", act12(), {3'd0, 4'd0, 2'd0, 4'd1, 1'b1, 1'b0});
    chk("1pm24", act24(), exp_pack(13, 0, 0, 0));

    // Table-driven set-mode corner cases.
    set_time(10, 59);
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].c, tbl[i].l, tbl[i].sm, tbl[i].sh);
      chk($sformatf("tbl24[%0d]", i), act24(), exp_pack(tbl[i].h, tbl[i].m, tbl[i].cd, 1'b0));
      chk($sformatf("tbl12[%0d]", i), act12(), exp_pack(tbl[i].h, tbl[i].m, tbl[i].cd, 1'b1));
    end
    tick(0, 0, 0, 0);

    // Asynchronous reset mid-count at 15:37, checked before the next edge.
    set_time(15, 37);
    chk("pre1537", act24(), exp_pack(15, 37, 0, 0));
    reset_n = 1'b0;
    #2;
    chk("async24", act24(), exp_pack(0, 0, 0, 0));
    chk("async12", act12(), {3'd0, 4'd0, 2'd1, 4'd2, 1'b0, 1'b0});
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    tick(0, 0, 0, 0);

    // Randomized run/set traffic against the model, starting near midnight.
    set_time(23, 50);
    begin
      bit lm = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 15) == 0) lm = ~lm;
        tick(1'($urandom_range(0, 1)), lm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
